// File: rtl/sr_encode_if.sv
// Field-bundle input and encoded-word output handshakes of the RV32I encoder.
// The master drives requests and consumes words; the slave is the encoder.
interface sr_encode_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_op;
  logic [4:0]        in_rd;
  logic [2:0]        in_f3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_f7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_op, in_rd, in_f3, in_rs1, in_rs2, in_f7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_rd, in_f3, in_rs1, in_rs2, in_f7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/sr_encode.sv
// Two-stage RV32I instruction encoder for the program loader: S1 holds the fields
// and the validity verdict, S2 holds the encoded word; malformed requests become a flagged NOP.
module sr_encode #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  sr_encode_if.slave bus
);
  localparam logic [2:0]        FMT_R = 3'd0;
  localparam logic [2:0]        FMT_I = 3'd1;
  localparam logic [2:0]        FMT_S = 3'd2;
  localparam logic [2:0]        FMT_B = 3'd3;
  localparam logic [2:0]        FMT_U = 3'd4;
  localparam logic [2:0]        FMT_J = 3'd5;
  localparam logic [31:0]       NOP   = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR0 = ADDR_W'(BASE_ADDR);

  // True when v[31:sh] are all copies of one bit, i.e. v fits a (sh+1)-bit signed field.
  function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] sh);
    logic [31:0] t;
    t = $signed(v) >>> sh;
    return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
  endfunction

  logic              r_s1_v;
  logic              r_s1_err;
  logic [2:0]        r_s1_fmt;
  logic [6:0]        r_s1_op;
  logic [4:0]        r_s1_rd;
  logic [2:0]        r_s1_f3;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [6:0]        r_s1_f7;
  logic [31:0]       r_s1_imm;
  logic              r_s2_v;
  logic [31:0]       r_instr;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_s2_adv;
  logic        w_s1_move;
  logic        w_fmt_err;
  logic        w_req_err;
  logic [31:0] w_enc;

  assign w_s2_adv   = ~r_s2_v | bus.out_ready;
  assign w_s1_move  = r_s1_v & w_s2_adv;
  assign w_in_ready = ~flush & (~r_s1_v | ~r_s2_v | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Immediate range/alignment check for the incoming format.
  always_comb begin
    case (bus.in_fmt)
      FMT_R:        w_fmt_err = 1'b0;
      FMT_I, FMT_S: w_fmt_err = ~fits_signed(bus.in_imm, 5'd11);
      FMT_B:        w_fmt_err = bus.in_imm[0] | ~fits_signed(bus.in_imm, 5'd12);
      FMT_U:        w_fmt_err = |bus.in_imm[11:0];
      FMT_J:        w_fmt_err = bus.in_imm[0] | ~fits_signed(bus.in_imm, 5'd20);
      default:      w_fmt_err = 1'b1;
    endcase
  end

  assign w_req_err = w_fmt_err | (bus.in_op[1:0] != 2'b11);

  // Field packing and immediate scatter from the S1 registers.
  always_comb begin
    w_enc = NOP;
    if (r_s1_err) begin
      w_enc = NOP;
    end else begin
      case (r_s1_fmt)
        FMT_R: w_enc = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        FMT_I: w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        FMT_S: w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
        FMT_B: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                        r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
        FMT_U: w_enc = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
        FMT_J: w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                        r_s1_rd, r_s1_op};
        default: w_enc = NOP;
      endcase
    end
  end

  // Stage 1: capture accepted fields and their verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_fmt <= 3'd0;
      r_s1_op  <= 7'd0;
      r_s1_rd  <= 5'd0;
      r_s1_f3  <= 3'd0;
      r_s1_rs1 <= 5'd0;
      r_s1_rs2 <= 5'd0;
      r_s1_f7  <= 7'd0;
      r_s1_imm <= 32'd0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
    end else if (w_accept) begin
      r_s1_v   <= 1'b1;
      r_s1_err <= w_req_err;
      r_s1_fmt <= bus.in_fmt;
      r_s1_op  <= bus.in_op;
      r_s1_rd  <= bus.in_rd;
      r_s1_f3  <= bus.in_f3;
      r_s1_rs1 <= bus.in_rs1;
      r_s1_rs2 <= bus.in_rs2;
      r_s1_f7  <= bus.in_f7;
      r_s1_imm <= bus.in_imm;
    end else if (w_s1_move) begin
      r_s1_v <= 1'b0;
    end
  end

  // Stage 2: output word, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_instr <= 32'd0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_s2_v <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_instr <= w_enc;
        r_err   <= r_s1_err;
      end
    end
  end

  // Word address advances on every consumed word, wrapping silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= ADDR0;
    end else if (flush) begin
      r_addr <= ADDR0;
    end else if (r_s2_v & bus.out_ready) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.out_instr = r_instr;
  assign bus.out_err   = r_err;
  assign bus.out_addr  = r_addr;
endmodule

// File: tb/tb_sr_encode.sv
// Directed bench for sr_encode: a queue-based reference model checked every cycle,
// plus hand-computed instruction words for the named scenarios.
module tb_sr_encode;
  localparam int AW = 2;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          t;
  } exp_t;

  typedef struct {
    logic [31:0]   instr;
    logic          err;
    logic [AW-1:0] addr;
    int            cyc;
  } log_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  log_t log_q[$];
  logic [AW-1:0] m_addr;

  sr_encode_if #(.ADDR_W(AW)) bus ();
  sr_encode #(.ADDR_W(AW), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic req_t mk(input int fmt, input int op, input int rd, input int f3,
                              input int rs1, input int rs2, input int f7, input logic [31:0] imm);
    req_t r;
    r.fmt = 3'(fmt); r.op = 7'(op); r.rd = 5'(rd); r.f3 = 3'(f3);
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.f7 = 7'(f7); r.imm = imm;
    return r;
  endfunction

  // Reference: range tests on the signed value, then shift/mask placement of each field.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int s;
    bit bad;
    logic [31:0] u, w, base;
    u = r.imm;
    s = $signed(r.imm);
    bad = (r.op % 7'd4) != 7'd3;
    base = 32'(r.op) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    w = 32'd0;
    case (r.fmt)
      3'd0: w = base | (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.f7) << 25);
      3'd1: begin
        bad = bad || s < -2048 || s > 2047;
        w = base | (32'(r.rd) << 7) | ((u & 32'hFFF) << 20);
      end
      3'd2: begin
        bad = bad || s < -2048 || s > 2047;
        w = base | ((u & 32'h1F) << 7) | (32'(r.rs2) << 20) | (((u >> 5) & 32'h7F) << 25);
      end
      3'd3: begin
        bad = bad || (u % 32'd2) != 32'd0 || s < -4096 || s > 4095;
        w = base | (32'(r.rs2) << 20) | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
            | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        bad = bad || (u % 32'd4096) != 32'd0;
        w = (u & 32'hFFFF_F000) | (32'(r.rd) << 7) | 32'(r.op);
      end
      3'd5: begin
        bad = bad || (u % 32'd2) != 32'd0 || s < -1048576 || s > 1048575;
        w = 32'(r.op) | (32'(r.rd) << 7) | (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
            | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12);
      end
      default: bad = 1'b1;
    endcase
    e.instr = bad ? 32'h0000_0013 : w;
    e.err   = bad;
    e.t     = 0;
    return e;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    req_t r;
    exp_t e;
    log_t l;
    bit   ev;
    if (rst) begin
      exp_q.delete();
      m_addr = '0;
    end else begin
      ev = (exp_q.size() > 0) && ((cyc - exp_q[0].t) >= 2);
      chk("mon_in_ready", 32'(bus.in_ready), 32'(!flush && (exp_q.size() < 2 || bus.out_ready)));
      chk("mon_out_valid", 32'(bus.out_valid), 32'(ev));
      if (flush) begin
        exp_q.delete();
        m_addr = '0;
      end else begin
        if (bus.out_valid && exp_q.size() > 0) begin
          chk("mon_instr", bus.out_instr, exp_q[0].instr);
          chk("mon_err", 32'(bus.out_err), 32'(exp_q[0].err));
          chk("mon_addr", 32'(bus.out_addr), 32'(m_addr));
          if (bus.out_ready) begin
            l.instr = bus.out_instr; l.err = bus.out_err; l.addr = bus.out_addr; l.cyc = cyc;
            log_q.push_back(l);
            void'(exp_q.pop_front());
            m_addr = m_addr + AW'(1);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          r = {bus.in_fmt, bus.in_op, bus.in_rd, bus.in_f3, bus.in_rs1, bus.in_rs2, bus.in_f7, bus.in_imm};
          e = model(r);
          e.t = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic send(input req_t r, input int budget, output bit ok);
    bit hs;
    bus.in_valid = 1'b1;
    bus.in_fmt = r.fmt; bus.in_op = r.op; bus.in_rd = r.rd; bus.in_f3 = r.f3;
    bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2; bus.in_f7 = r.f7; bus.in_imm = r.imm;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      ok = hs;
    end
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    bus.in_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_valid) && i < 60) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({nm, "_drain"}, 32'(i < 60), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] ins,
                         input logic err, input logic [AW-1:0] a);
    chk({nm, "_present"}, 32'(log_q.size() > idx), 32'd1);
    if (log_q.size() > idx) begin
      chk({nm, "_instr"}, log_q[idx].instr, ins);
      chk({nm, "_err"}, 32'(log_q[idx].err), 32'(err));
      chk({nm, "_addr"}, 32'(log_q[idx].addr), 32'(a));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int b;
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    bus.in_fmt = '0; bus.in_op = '0; bus.in_rd = '0; bus.in_f3 = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_f7 = '0; bus.in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // addi x1,x0,5 and its two-edge latency
    send(mk(1, 8'h13, 1, 0, 0, 0, 0, 32'd5), 4, ok);
    chk("t1_acc", 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_instr", bus.out_instr, 32'h0050_0093);
    chk("t1_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;

    b = log_q.size();
    send(mk(3, 8'h63, 0, 0, 1, 2, 0, -32'sd8), 4, ok);
    send(mk(4, 8'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 4, ok);
    drain("t2");
    chk_log("t2_beq", b, 32'hFE20_8CE3, 1'b0, 2'd1);
    chk_log("t2_lui", b + 1, 32'h1234_52B7, 1'b0, 2'd2);

    b = log_q.size();
    send(mk(5, 8'h6F, 1, 0, 0, 0, 0, 32'd3), 4, ok);
    send(mk(1, 8'h13, 1, 0, 0, 0, 0, 32'd2048), 4, ok);
    send(mk(7, 8'h13, 1, 0, 0, 0, 0, 32'd0), 4, ok);
    send(mk(1, 8'h12, 1, 0, 0, 0, 0, 32'd1), 4, ok);
    drain("t3");
    chk_log("t3_jal_odd", b, 32'h0000_0013, 1'b1, 2'd3);
    chk_log("t3_addi_big", b + 1, 32'h0000_0013, 1'b1, 2'd0);
    chk_log("t3_fmt7", b + 2, 32'h0000_0013, 1'b1, 2'd1);
    chk_log("t3_badop", b + 3, 32'h0000_0013, 1'b1, 2'd2);

    // backpressure: only two bundles fit, then release in order
    do_flush();
    b = log_q.size();
    bus.out_ready = 1'b0;
    send(mk(1, 8'h13, 2, 0, 0, 0, 0, 32'd1), 3, ok);
    chk("t4_acc_a", 32'(ok), 32'd1);
    send(mk(1, 8'h13, 3, 0, 0, 0, 0, 32'd2), 3, ok);
    chk("t4_acc_b", 32'(ok), 32'd1);
    send(mk(1, 8'h13, 4, 0, 0, 0, 0, 32'd3), 4, ok);
    chk("t4_acc_c_blocked", 32'(ok), 32'd0);
    @(negedge clk);
    chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("t4_hold_instr", bus.out_instr, 32'h0010_0113);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(mk(1, 8'h13, 4, 0, 0, 0, 0, 32'd3), 3, ok);
    chk("t4_acc_c", 32'(ok), 32'd1);
    drain("t4");
    chk_log("t4_a", b, 32'h0010_0113, 1'b0, 2'd0);
    chk_log("t4_b", b + 1, 32'h0020_0193, 1'b0, 2'd1);
    chk_log("t4_c", b + 2, 32'h0030_0213, 1'b0, 2'd2);

    // full rate with address wrap
    do_flush();
    b = log_q.size();
    send(mk(0, 8'h33, 3, 0, 1, 2, 7'h00, 32'd0), 1, ok); chk("t5_acc0", 32'(ok), 32'd1);
    send(mk(0, 8'h33, 4, 0, 1, 2, 7'h20, 32'd0), 1, ok); chk("t5_acc1", 32'(ok), 32'd1);
    send(mk(2, 8'h23, 0, 2, 1, 2, 0, -32'sd4), 1, ok);   chk("t5_acc2", 32'(ok), 32'd1);
    send(mk(5, 8'h6F, 1, 0, 0, 0, 0, 32'd2048), 1, ok);  chk("t5_acc3", 32'(ok), 32'd1);
    send(mk(4, 8'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 1, ok); chk("t5_acc4", 32'(ok), 32'd1);
    drain("t5");
    chk_log("t5_add", b, 32'h0020_81B3, 1'b0, 2'd0);
    chk_log("t5_sub", b + 1, 32'h4020_8233, 1'b0, 2'd1);
    chk_log("t5_sw", b + 2, 32'hFE20_AE23, 1'b0, 2'd2);
    chk_log("t5_jal", b + 3, 32'h0010_00EF, 1'b0, 2'd3);
    chk_log("t5_lui", b + 4, 32'h1234_52B7, 1'b0, 2'd0);
    for (int k = 1; k < 5; k++) begin
      if (log_q.size() > b + k)
        chk("t5_rate", 32'(log_q[b + k].cyc - log_q[b + k - 1].cyc), 32'd1);
    end

    // flush with two words in flight, racing both handshakes
    bus.out_ready = 1'b0;
    send(mk(1, 8'h13, 6, 0, 0, 0, 0, 32'd6), 3, ok);
    send(mk(1, 8'h13, 7, 0, 0, 0, 0, 32'd7), 3, ok);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_flush_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;
    b = log_q.size();
    send(mk(1, 8'h13, 8, 0, 0, 0, 0, 32'd8), 3, ok);
    drain("t6a");
    chk("t6_flush_count", 32'(log_q.size()), 32'(b + 1));
    chk_log("t6_after_flush", b, 32'h0080_0413, 1'b0, 2'd0);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send(mk(1, 8'h13, 9, 0, 0, 0, 0, 32'd9), 3, ok);
    send(mk(1, 8'h13, 10, 0, 0, 0, 0, 32'd10), 3, ok);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    b = log_q.size();
    send(mk(1, 8'h13, 5, 0, 0, 0, 0, 32'd7), 3, ok);
    drain("t6b");
    chk("t6_rst_count", 32'(log_q.size()), 32'(b + 1));
    chk_log("t6_after_rst", b, 32'h0070_0293, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
